// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t       : FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/result width
package serial_add_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_fa_bit.sv
// fa_bit: one-bit full adder built from two half-adder stages and an OR.
// Purely combinational; the carry register lives in the caller.
//   a, b   : operand bits
//   ci     : carry in
//   s_c    : sum bit
//   co_c   : carry out
module fa_bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s_c,
   output logic co_c
);

   logic p_c;
   logic g1_c;
   logic g2_c;

   // First half adder: propagate and generate from the operand bits
   assign p_c  = a ^ b;
   assign g1_c = a & b;

   // Second half adder: fold in the carry
   assign s_c  = p_c ^ ci;
   assign g2_c = p_c & ci;

   assign co_c = g1_c | g2_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller. Operands are latched on an
// accepted start and fed LSB-first through a single fa_bit, one bit per cycle.
// Optional macro SERIAL_ADD_SUB_EN enables subtraction (a - b) via sub.
//   clk, rst : clock, synchronous active-high reset
//   start    : request an operation (accepted in IDLE or DONE)
//   a, b     : operands, sampled on an accepted start
//   sub      : subtract select (only honoured with SERIAL_ADD_SUB_EN)
//   busy     : bits being processed
//   done     : one-cycle pulse when sum/cout are updated
//   sum      : registered result, held until the next completion
//   cout     : registered carry-out (no-borrow when subtracting)
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state;
   state_t             state_next;
   logic               accept_c;
   logic               last_c;
   logic               sub_sel_c;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-1:0]   res_sr;
   logic               carry;
   logic [CNT_W-1:0]   cnt;
   logic               s_c;
   logic               c_next_c;

   // Subtraction support is compiled in only when requested
`ifdef SERIAL_ADD_SUB_EN
   assign sub_sel_c = sub;
`else
   logic unused_sub_c;
   assign unused_sub_c = sub;
   assign sub_sel_c    = 1'b0;
`endif

   // The single time-shared one-bit adder cell
   fa_bit u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .ci   (carry),
      .s_c  (s_c),
      .co_c (c_next_c)
   );

   assign last_c = (cnt == CNT_LAST);

   // Next-state logic
   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
               accept_c   = 1'b1;
            end
         end
         RUN: begin
            if (last_c) state_next = DONE;
         end
         DONE: begin
            if (start) begin
               state_next = RUN;
               accept_c   = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, status outputs and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
         carry  <= 1'b0;
         cnt    <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
      end else begin
         state <= state_next;
         busy  <= (state_next == RUN);
         done  <= (state_next == DONE);
         if (accept_c) begin
            a_sr  <= a;
            // Two's-complement subtract: invert b and inject a carry-in of 1
            b_sr  <= sub_sel_c ? ~b : b;
            carry <= sub_sel_c;
            cnt   <= '0;
         end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            carry  <= c_next_c;
            cnt    <= cnt + CNT_W'(1);
            res_sr <= {s_c, res_sr[WIDTH-1:1]};
            if (last_c) begin
               sum  <= {s_c, res_sr[WIDTH-1:1]};
               cout <= c_next_c;
            end
         end
      end
   end

endmodule
